// File: rtl/led_pkg.sv
// Shared mode encoding and wr_data field layout for led_driver and led_channel.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_PWM   = 2'd3
    } led_mode_e;

    localparam int unsigned MODE_W = 2;

    // The mode field sits directly above the duty field in wr_data.
    function automatic int unsigned mode_lsb(input int unsigned pwm_bits);
        return pwm_bits;
    endfunction

    function automatic int unsigned mode_msb(input int unsigned pwm_bits);
        return pwm_bits + MODE_W - 1;
    endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/duty registers, lit decision and registered pin drive.
// Optional duty fading is enabled with the LED_DRIVER_FADE_EN macro.
module led_channel
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS   = 8,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [PWM_BITS+MODE_W-1:0] wr_data,
    input  logic [PWM_BITS-1:0]        pwm_cnt,
    input  logic                       blink_phase,
`ifdef LED_DRIVER_FADE_EN
    input  logic                       fade_tick,
`endif
    output logic                       led
);

    localparam int unsigned ModeLsb = mode_lsb(PWM_BITS);
    localparam int unsigned ModeMsb = mode_msb(PWM_BITS);

    led_mode_e           mode_q;
    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] cmp_duty;
    logic                lit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= LED_OFF;
            duty_q <= '0;
        end else if (wr_en) begin
            mode_q <= led_mode_e'(wr_data[ModeMsb:ModeLsb]);
            duty_q <= wr_data[PWM_BITS-1:0];
        end
    end

`ifdef LED_DRIVER_FADE_EN
    logic [PWM_BITS-1:0] cur_duty_q;

    // Mode writes stay immediate; only the compare level walks toward the target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_duty_q <= '0;
        end else if (fade_tick) begin
            if (cur_duty_q < duty_q) begin
                cur_duty_q <= cur_duty_q + PWM_BITS'(1);
            end else if (cur_duty_q > duty_q) begin
                cur_duty_q <= cur_duty_q - PWM_BITS'(1);
            end
        end
    end

    assign cmp_duty = cur_duty_q;
`else
    assign cmp_duty = duty_q;
`endif

    always_comb begin
        lit = 1'b0;
        case (mode_q)
            LED_OFF:   lit = 1'b0;
            LED_ON:    lit = 1'b1;
            LED_BLINK: lit = blink_phase && (pwm_cnt < cmp_duty);
            LED_PWM:   lit = (pwm_cnt < cmp_duty);
            default:   lit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= ACTIVE_LOW;
        end else begin
            led <= lit ^ ACTIVE_LOW;
        end
    end

endmodule

// File: rtl/led_driver.sv
// Multi-channel LED driver: shared PWM/blink timebase feeding N_LEDS led_channel instances.
// Define LED_DRIVER_FADE_EN to add per-channel duty fading paced by FADE_DIV.
module led_driver
    import led_pkg::*;
#(
    parameter int unsigned N_LEDS     = 5,
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned BLINK_DIV  = 6000000,
    parameter bit          ACTIVE_LOW = 1'b0,
    parameter int unsigned FADE_DIV   = 4096,
    localparam int unsigned ADDR_W    = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [PWM_BITS+MODE_W-1:0] wr_data,
    output logic [N_LEDS-1:0]          led,
    output logic                       pwm_sync,
    output logic                       blink_phase
);

    localparam int unsigned BLINK_W = $clog2(BLINK_DIV);

    if (N_LEDS < 1 || N_LEDS > 32 || BLINK_DIV < 2 || FADE_DIV < 1) begin : g_bad_params
        $error("led_driver: N_LEDS must be 1..32, BLINK_DIV >= 2, FADE_DIV >= 1");
    end

    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [BLINK_W-1:0]  blink_cnt_q;
    logic                blink_wrap;

    assign blink_wrap = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_q <= '0;
            pwm_sync  <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
            // Registered alongside led so the pulse lines up with the first lit cycle.
            pwm_sync  <= (pwm_cnt_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_phase <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt_q <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
        end
    end

`ifdef LED_DRIVER_FADE_EN
    localparam int unsigned FADE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    logic [FADE_W-1:0] fade_cnt_q;
    logic              fade_tick;

    assign fade_tick = (fade_cnt_q == FADE_W'(FADE_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fade_cnt_q <= '0;
        end else if (fade_tick) begin
            fade_cnt_q <= '0;
        end else begin
            fade_cnt_q <= fade_cnt_q + FADE_W'(1);
        end
    end
`endif

    // Out-of-range addresses match no channel, so such writes fall away.
    for (genvar i = 0; i < int'(N_LEDS); i++) begin : g_ch
        logic ch_wr_en;

        assign ch_wr_en = wr_en && (wr_addr == ADDR_W'(i));

        led_channel #(
            .PWM_BITS   (PWM_BITS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_channel (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_en       (ch_wr_en),
            .wr_data     (wr_data),
            .pwm_cnt     (pwm_cnt_q),
            .blink_phase (blink_phase),
`ifdef LED_DRIVER_FADE_EN
            .fade_tick   (fade_tick),
`endif
            .led         (led[i])
        );
    end

endmodule

// File: tb/tb_led_driver.sv
// Self-checking bench for led_driver: directed table, latency/reset sequences, random vs. model.
module tb_led_driver;

    localparam int unsigned N_LEDS     = 5;
    localparam int unsigned PWM_BITS   = 4;
    localparam int unsigned BLINK_DIV  = 8;
    localparam int unsigned FADE_DIV   = 4;
    localparam bit          ACTIVE_LOW = 1'b0;
    localparam int unsigned AW         = 3;
    localparam int unsigned DW         = PWM_BITS + 2;
    localparam int unsigned PERIOD     = 1 << PWM_BITS;
    localparam logic [N_LEDS-1:0] INACTIVE = ACTIVE_LOW ? {N_LEDS{1'b1}} : {N_LEDS{1'b0}};

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              wr_en = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic [N_LEDS-1:0] led;
    logic              pwm_sync;
    logic              blink_phase;

    always #5 clk = ~clk;

    led_driver #(
        .N_LEDS     (N_LEDS),
        .PWM_BITS   (PWM_BITS),
        .BLINK_DIV  (BLINK_DIV),
        .ACTIVE_LOW (ACTIVE_LOW),
        .FADE_DIV   (FADE_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .led         (led),
        .pwm_sync    (pwm_sync),
        .blink_phase (blink_phase)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: counters derived from the number of edges since reset.
    int unsigned       m_edges;
    int                m_mode [N_LEDS];
    int                m_duty [N_LEDS];
    int                m_cur  [N_LEDS];
    logic [N_LEDS-1:0] exp_led;
    logic              exp_sync;
    logic              exp_phase;

    always @(posedge clk or negedge rst_n) begin : model
        int  pc;
        int  ph;
        int  eff;
        bit  lit;
        if (!rst_n) begin
            m_edges   = 0;
            exp_led   = INACTIVE;
            exp_sync  = 1'b0;
            exp_phase = 1'b0;
            for (int i = 0; i < int'(N_LEDS); i++) begin
                m_mode[i] = 0;
                m_duty[i] = 0;
                m_cur[i]  = 0;
            end
        end else begin
            pc = int'(m_edges % PERIOD);
            ph = int'((m_edges / BLINK_DIV) % 2);
            for (int i = 0; i < int'(N_LEDS); i++) begin
`ifdef LED_DRIVER_FADE_EN
                eff = m_cur[i];
`else
                eff = m_duty[i];
`endif
                case (m_mode[i])
                    1:       lit = 1'b1;
                    2:       lit = (ph == 1) && (pc < eff);
                    3:       lit = (pc < eff);
                    default: lit = 1'b0;
                endcase
                exp_led[i] = lit ^ ACTIVE_LOW;
            end
            exp_sync  = (pc == 0);
            m_edges   = m_edges + 1;
            exp_phase = ((m_edges / BLINK_DIV) % 2) == 1;
`ifdef LED_DRIVER_FADE_EN
            if (m_edges % FADE_DIV == 0) begin
                for (int i = 0; i < int'(N_LEDS); i++) begin
                    if (m_cur[i] < m_duty[i]) m_cur[i] = m_cur[i] + 1;
                    else if (m_cur[i] > m_duty[i]) m_cur[i] = m_cur[i] - 1;
                end
            end
`endif
            if (wr_en && int'(wr_addr) < int'(N_LEDS)) begin
                m_mode[wr_addr] = int'(wr_data[DW-1:PWM_BITS]);
                m_duty[wr_addr] = int'(wr_data[PWM_BITS-1:0]);
            end
        end
    end

    task automatic check_model(input string name);
        vectors++;
        if (led !== exp_led || pwm_sync !== exp_sync || blink_phase !== exp_phase) begin
            miscompares++;
            $display("FAIL %s @%0t: got led=%b sync=%b phase=%b, expected led=%b sync=%b phase=%b",
                     name, $time, led, pwm_sync, blink_phase, exp_led, exp_sync, exp_phase);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, want);
        end
    endtask

    task automatic step(input string name);
        @(posedge clk);
        #1;
        check_model(name);
    endtask

    task automatic write_cfg(input int addr, input int mode, input int duty);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = {2'(mode), PWM_BITS'(duty)};
        step("write");
        wr_en   = 1'b0;
    endtask

    // Drop reset between edges and check outputs clear without a clock edge.
    task automatic async_reset(input string name);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_int({name, "_led"}, int'(led), int'(INACTIVE));
        check_int({name, "_sync"}, int'(pwm_sync), 0);
        check_int({name, "_phase"}, int'(blink_phase), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step({name, "_first_edge"});
        check_int({name, "_first_sync"}, int'(pwm_sync), 1);
    endtask

    typedef struct {
        int addr;
        int mode;
        int duty;
        int obs;
        int exp_cnt;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int cnt;
        int sync_cnt;

        // Expected lit counts over 32 cycles (two PWM periods, one full blink cycle pair).
        tbl[0]  = '{addr: 0, mode: 1, duty: 0,  obs: 0, exp_cnt: 32};
        tbl[1]  = '{addr: 2, mode: 3, duty: 4,  obs: 2, exp_cnt: 8};
        tbl[2]  = '{addr: 2, mode: 3, duty: 0,  obs: 2, exp_cnt: 0};
        tbl[3]  = '{addr: 2, mode: 3, duty: 15, obs: 2, exp_cnt: 30};
        tbl[4]  = '{addr: 1, mode: 2, duty: 15, obs: 1, exp_cnt: 14};
        tbl[5]  = '{addr: 1, mode: 2, duty: 4,  obs: 1, exp_cnt: 0};
        tbl[6]  = '{addr: 1, mode: 2, duty: 12, obs: 1, exp_cnt: 8};
        tbl[7]  = '{addr: 3, mode: 3, duty: 8,  obs: 3, exp_cnt: 16};
        tbl[8]  = '{addr: 3, mode: 0, duty: 15, obs: 3, exp_cnt: 0};
        tbl[9]  = '{addr: 7, mode: 1, duty: 0,  obs: 4, exp_cnt: 0};
        tbl[10] = '{addr: 5, mode: 1, duty: 0,  obs: 4, exp_cnt: 0};
        tbl[11] = '{addr: 4, mode: 1, duty: 9,  obs: 4, exp_cnt: 32};

        #1;
        rst_n = 1'b0;
        #20;
        check_int("reset_led", int'(led), int'(INACTIVE));
        check_int("reset_sync", int'(pwm_sync), 0);
        check_int("reset_phase", int'(blink_phase), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step("first_edge");
        check_int("first_sync", int'(pwm_sync), 1);

        // Strobe at edge k, pin follows at edge k+1.
        write_cfg(0, 1, 0);
        check_int("on_latency_k", int'(led[0] ^ ACTIVE_LOW), 0);
        step("on_k1");
        check_int("on_latency_k1", int'(led[0] ^ ACTIVE_LOW), 1);

        sync_cnt = 0;
        for (int c = 0; c < 48; c++) begin
            step("sync_period");
            sync_cnt += int'(pwm_sync);
        end
        check_int("sync_per_48", sync_cnt, 3);

        async_reset("async_rst");

        for (int v = 0; v < 12; v++) begin
            write_cfg(tbl[v].addr, tbl[v].mode, tbl[v].duty);
            for (int c = 0; c < 80; c++) step("settle");
            cnt = 0;
            for (int c = 0; c < 32; c++) begin
                step("window");
                cnt += int'(led[tbl[v].obs] ^ ACTIVE_LOW);
            end
            check_int($sformatf("table%0d_lit_count", v), cnt, tbl[v].exp_cnt);
        end

        for (int c = 0; c < 1500; c++) begin
            if (c == 700) async_reset("rand_async_rst");
            if ($urandom_range(0, 3) == 0) begin
                write_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, PERIOD - 1)));
            end else begin
                step("random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
